// File: rtl/phy_defs.sv
// Shared definitions for the two-lane receive PHY: alignment symbol, widths,
// lane count, lane FSM encodings and the slot classification helper.
package phy_defs;

    localparam logic [7:0] COM_SYM   = 8'hBC;
    localparam int         BYTE_W    = 8;
    localparam int         LANES     = 2;
    localparam int         WORD_W    = 32;
    localparam int         COM_LOCK  = 4;
    localparam int         COM_CNT_W = $clog2(COM_LOCK + 1);

    typedef enum logic [1:0] {
        LANE_SEARCH  = 2'd0,
        LANE_LOCKING = 2'd1,
        LANE_LOCKED  = 2'd2
    } lane_state_e;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_FIRST = 2'd1,
        SLOT_WORD  = 2'd2,
        SLOT_ERR   = 2'd3
    } slot_kind_e;

    // A deskewed slot is idle when both lanes carry COM outside a word, the
    // first or second half of a word when both carry data, and a framing
    // error otherwise (mixed COM/data, or COM arriving in the middle of a word).
    function automatic slot_kind_e classify_slot(input logic com0, input logic com1,
                                                 input logic phase);
        if (com0 && com1)   return phase ? SLOT_ERR : SLOT_IDLE;
        if (!com0 && !com1) return phase ? SLOT_WORD : SLOT_FIRST;
        return SLOT_ERR;
    endfunction

endpackage

// File: rtl/phy_rx_deserializer_if.sv
// Receive-side word bus of phy_rx_deserializer plus lane FSM debug state.
// The optional err_count_rx field exists only with PHY_RX_ERR_CNT_EN defined.
//
// Handshake: valid_out_rx is a one-cycle strobe with no backpressure; the
// consumer must take data_out_rx in the cycle valid_out_rx is high. err_rx is
// an independent one-cycle strobe. active_rx is a level.
interface phy_rx_deserializer_if;
    import phy_defs::*;

    logic [WORD_W-1:0] data_out_rx;
    logic              valid_out_rx;
    logic              active_rx;
    logic              err_rx;
`ifdef PHY_RX_ERR_CNT_EN
    logic [7:0]        err_count_rx;
`endif
    lane_state_e       lane0_state;
    lane_state_e       lane1_state;

    modport master (
        output data_out_rx, valid_out_rx, active_rx, err_rx,
`ifdef PHY_RX_ERR_CNT_EN
        output err_count_rx,
`endif
        output lane0_state, lane1_state
    );

    modport slave (
        input data_out_rx, valid_out_rx, active_rx, err_rx,
`ifdef PHY_RX_ERR_CNT_EN
        input err_count_rx,
`endif
        input lane0_state, lane1_state
    );

endinterface

// File: rtl/phy_rx_lane_align.sv
// Per-lane byte aligner: hunts for COM on any bit offset, confirms it on
// COM_LOCK consecutive byte boundaries, then emits one byte per 8 bits.
module phy_rx_lane_align
    import phy_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              is_com,
    output logic              byte_vld,
    output logic              locked,
    output lane_state_e       state_dbg
);

    localparam logic [COM_CNT_W-1:0] COM_LAST = COM_CNT_W'(COM_LOCK - 1);

    lane_state_e           state_q, state_d;
    logic [BYTE_W-1:0]     sr_q, sr_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [COM_CNT_W-1:0]  com_cnt_q, com_cnt_d;
    logic [BYTE_W-1:0]     byte_q, byte_d;
    logic                  is_com_q, is_com_d;
    logic                  vld_q, vld_d;
    logic [BYTE_W-1:0]     nxt;

    // Next-state: shift in the bit, walk the alignment FSM, capture bytes.
    always_comb begin
        nxt       = {sr_q[BYTE_W-2:0], bit_in};
        sr_d      = nxt;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        byte_d    = byte_q;
        is_com_d  = is_com_q;
        vld_d     = 1'b0;
        case (state_q)
            LANE_SEARCH: begin
                bit_cnt_d = 3'd0;
                if (nxt == COM_SYM) begin
                    state_d   = LANE_LOCKING;
                    com_cnt_d = COM_CNT_W'(1);
                end
            end
            LANE_LOCKING: begin
                if (bit_cnt_q == 3'd7) begin
                    if (nxt == COM_SYM) begin
                        com_cnt_d = com_cnt_q + 1'b1;
                        if (com_cnt_q == COM_LAST) state_d = LANE_LOCKED;
                    end else begin
                        state_d   = LANE_SEARCH;
                        com_cnt_d = '0;
                    end
                end
            end
            LANE_LOCKED: begin
                if (bit_cnt_q == 3'd7) begin
                    byte_d   = nxt;
                    is_com_d = (nxt == COM_SYM);
                    vld_d    = 1'b1;
                end
            end
            default: state_d = LANE_SEARCH;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= LANE_SEARCH;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            byte_q    <= '0;
            is_com_q  <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            byte_q    <= byte_d;
            is_com_q  <= is_com_d;
            vld_q     <= vld_d;
        end
    end

    assign rx_byte   = byte_q;
    assign is_com    = is_com_q;
    assign byte_vld  = vld_q;
    assign locked    = (state_q == LANE_LOCKED);
    assign state_dbg = state_q;

endmodule

// File: rtl/phy_rx_deserializer.sv
// Two-lane receive PHY: per-lane alignment, one-byte deskew and 32-bit word
// assembly. Lane 0 carries data[31:16], lane 1 carries data[15:0].
// Optional build macro PHY_RX_ERR_CNT_EN adds a saturating err_count_rx.
module phy_rx_deserializer
    import phy_defs::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        data_in_lane_0_rx,
    input  logic                        data_in_lane_1_rx,
    phy_rx_deserializer_if.master       rx
);

    logic [LANES-1:0][BYTE_W-1:0] lane_byte;
    logic [LANES-1:0]             lane_com;
    logic [LANES-1:0]             lane_vld;
    logic [LANES-1:0]             lane_locked;
    lane_state_e                  lane_state [LANES];

    phy_rx_lane_align u_lane0 (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (data_in_lane_0_rx),
        .rx_byte   (lane_byte[0]),
        .is_com    (lane_com[0]),
        .byte_vld  (lane_vld[0]),
        .locked    (lane_locked[0]),
        .state_dbg (lane_state[0])
    );

    phy_rx_lane_align u_lane1 (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (data_in_lane_1_rx),
        .rx_byte   (lane_byte[1]),
        .is_com    (lane_com[1]),
        .byte_vld  (lane_vld[1]),
        .locked    (lane_locked[1]),
        .state_dbg (lane_state[1])
    );

    logic                         active_q, active_d;
    logic [LANES-1:0][BYTE_W-1:0] hold_q, hold_d;
    logic [LANES-1:0]             hold_com_q, hold_com_d;
    logic [LANES-1:0]             full_q, full_d;
    logic                         slot_vld_q, slot_vld_d;
    logic [LANES-1:0][BYTE_W-1:0] slot_byte_q, slot_byte_d;
    logic [LANES-1:0]             slot_com_q, slot_com_d;
    logic                         phase_q, phase_d;
    logic [BYTE_W-1:0]            hi_q, hi_d;
    logic [BYTE_W-1:0]            mid_q, mid_d;
    logic [WORD_W-1:0]            data_q, data_d;
    logic                         valid_q, valid_d;
    logic                         err_q, err_d;

    logic [LANES-1:0][BYTE_W-1:0] eff_byte;
    logic [LANES-1:0]             eff_com;
    logic [LANES-1:0]             eff_full;

    // Deskew into one-byte holders, then decode the previous cycle's slot.
    // A byte strobing in the same cycle counts as already held, so aligned
    // lanes complete a slot without waiting an extra cycle.
    always_comb begin
        active_d    = lane_locked[0] & lane_locked[1];
        hold_d      = hold_q;
        hold_com_d  = hold_com_q;
        full_d      = full_q;
        slot_vld_d  = 1'b0;
        slot_byte_d = slot_byte_q;
        slot_com_d  = slot_com_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        mid_d       = mid_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        eff_full    = full_q | lane_vld;
        for (int i = 0; i < LANES; i++) begin
            eff_byte[i] = lane_vld[i] ? lane_byte[i] : hold_q[i];
            eff_com[i]  = lane_vld[i] ? lane_com[i]  : hold_com_q[i];
        end

        if (active_q) begin
            if ((lane_vld & full_q) != '0) err_d = 1'b1;
            if (eff_full == '1) begin
                slot_vld_d  = 1'b1;
                slot_byte_d = eff_byte;
                slot_com_d  = eff_com;
                full_d      = '0;
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    if (lane_vld[i]) begin
                        hold_d[i]     = lane_byte[i];
                        hold_com_d[i] = lane_com[i];
                        full_d[i]     = 1'b1;
                    end
                end
            end
        end

        if (slot_vld_q) begin
            case (classify_slot(slot_com_q[0], slot_com_q[1], phase_q))
                SLOT_IDLE: phase_d = 1'b0;
                SLOT_FIRST: begin
                    hi_d    = slot_byte_q[0];
                    mid_d   = slot_byte_q[1];
                    phase_d = 1'b1;
                end
                SLOT_WORD: begin
                    data_d  = {hi_q, slot_byte_q[0], mid_q, slot_byte_q[1]};
                    valid_d = 1'b1;
                    phase_d = 1'b0;
                end
                default: begin
                    err_d   = 1'b1;
                    phase_d = 1'b0;
                end
            endcase
        end
    end

    // Deskew and word registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q    <= 1'b0;
            hold_q      <= '0;
            hold_com_q  <= '0;
            full_q      <= '0;
            slot_vld_q  <= 1'b0;
            slot_byte_q <= '0;
            slot_com_q  <= '0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            mid_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            active_q    <= active_d;
            hold_q      <= hold_d;
            hold_com_q  <= hold_com_d;
            full_q      <= full_d;
            slot_vld_q  <= slot_vld_d;
            slot_byte_q <= slot_byte_d;
            slot_com_q  <= slot_com_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            mid_q       <= mid_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

`ifdef PHY_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Count error strobes, sticking at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (!reset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign rx.err_count_rx = err_cnt_q;
`endif

    assign rx.data_out_rx  = data_q;
    assign rx.valid_out_rx = valid_q;
    assign rx.active_rx    = active_q;
    assign rx.err_rx       = err_q;
    assign rx.lane0_state  = lane_state[0];
    assign rx.lane1_state  = lane_state[1];

endmodule

// File: doc/phy_rx_deserializer.md
Name: phy_rx_deserializer

Overview:
Receive-side PHY for the two-lane serial link driven by phy_tx. It recovers byte alignment on each serial lane using COM (0xBC) idle symbols, deskews the two lanes by up to one byte, and reassembles 32-bit words. Words are presented with a one-cycle valid strobe. It sits between the serial lanes and the receive-side logic, running on the bit-rate clock (the 32f clock of the transmitter).

Parameters:
COM_SYM, 8'hBC, idle/alignment symbol.
COM_LOCK, 4, consecutive byte-aligned COMs required for a lane to lock.

Ports:
clk  input  1  bit-rate clock; all logic on posedge.
reset  input  1  synchronous, active-low reset.
data_in_lane_0_rx  input  1  serial lane 0, MSB-first; carries data[31:16].
data_in_lane_1_rx  input  1  serial lane 1, MSB-first; carries data[15:0].
data_out_rx  output  32  reassembled word.
valid_out_rx  output  1  one-cycle strobe; data_out_rx is valid when this is high.
active_rx  output  1  high while both lanes are locked.
err_rx  output  1  one-cycle framing-error strobe.

Behaviour:
- Reset (reset==0 at posedge) clears the following to 0: data_out_rx, valid_out_rx, active_rx, err_rx, all shift, holding and phase registers. Both lane FSMs go to SEARCH. Reset has priority over all other activity, including mid-word; any partial word is discarded.
- Per lane, every cycle: sr <= {sr[6:0], bit}. Define nxt = {sr[6:0], bit}.
- Lane FSM states:
  - SEARCH:
    - nxt==COM_SYM -> LOCKING, com_cnt=1, bit_cnt=0.
  - LOCKING: bit_cnt counts 0..7. At bit_cnt==7 (byte boundary):
    - nxt==COM_SYM: com_cnt++; if com_cnt reaches COM_LOCK -> LOCKED.
    - otherwise -> SEARCH, com_cnt=0.
  - LOCKED:
    - At each byte boundary, register byte=nxt, is_com=(nxt==COM_SYM), and pulse byte_vld for one cycle.
    - Stays LOCKED until reset.
- active_rx is high when both lanes are LOCKED (registered).
- Deskew:
  - Each lane has a one-byte holding register with a full flag.
  - A slot completes when both are full, or when one is full and the other lane strobes in the same cycle.
  - On slot completion, both full flags clear. A lane strobe into an already-full holder overwrites it and pulses err_rx. This supports skew of up to 7 bits.
- Slot decode, with phase starting at 0:
  - Both COM: idle, phase=0, no output.
  - Both data, phase 0: capture lane0->[31:24], lane1->[15:8]; phase=1.
  - Both data, phase 1: data_out_rx <= {hold31_24, lane0, hold15_8, lane1}; valid_out_rx pulses; phase=0.
  - Mixed COM/data, or COM while phase==1: err_rx pulses, partial word discarded, phase=0, no valid.
- Latency: valid_out_rx goes high 2 posedges after the posedge that samples the last bit of the later lane's final byte. data_out_rx holds its value until the next valid word.
- No slots are decoded while active_rx==0.

Optional Feature:
PHY_RX_ERR_CNT_EN:
- Defined: adds output err_count_rx [7:0]. It increments on each err_rx pulse, saturates at 8'hFF, and clears on reset.
- Undefined: the port and counter are absent; err_rx behaviour is unchanged.

Decomposition:
- Shared package/include phy_defs: COM_SYM value, byte width 8, lane count 2, lane FSM state encodings (SEARCH, LOCKING, LOCKED).
- Sub-module phy_rx_lane_align, instantiated twice:
  - inputs: clk, reset, serial bit.
  - outputs: byte, is_com, byte_vld, locked.
- Deskew and word assembly live in the top module.

Test Plan:
1. Hold reset=0 for 3 cycles while toggling both lanes -> all outputs 0, active_rx=0.
2. After 3 garbage bits, each lane sends 4x 0xBC -> active_rx=1 after the 4th COM. Sending only 3 COMs followed by 0x00 -> active_rx stays 0.
3. Locked; lane0 sends DE,AD and lane1 sends BE,EF, then COMs -> single valid_out_rx pulse with data_out_rx=32'hDEADBEEF, err_rx=0.
4. Lane1 delayed 3 bits vs lane0, word 32'h12345678 -> one valid pulse with data_out_rx=32'h12345678, no err_rx.
5. Lane0 sends COM while lane1 sends 0x55 in the same slot -> err_rx pulse, no valid. The following word 32'hAAAAAAAA is received correctly. With PHY_RX_ERR_CNT_EN, err_count_rx=1.
6. Reset asserted after the first data slot of a word -> no valid_out_rx, active_rx=0. Relock with 4 COMs, then 32'hCCCCCCCC is received correctly.
